dac7611_arbiter: RTL and testbench



---
 rtl/dac7611_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_dac7611_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dac7611_arbiter.sv
// Round-robin arbiter that shares one DAC7611 serial DAC among NUM_REQ requesters.
// Optional macro DAC_CLR_ON_RESET_EN: issue a DAC clear automatically after reset.
module dac7611_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int HALF_PERIOD = 2,
  parameter int LD_CYCLES   = 2,
  parameter int GAP_CYCLES  = 4,
  parameter int CLR_CYCLES  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [12*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic                   clr_req,
  output logic                   clr_ack,
  output logic                   busy,
  output logic [2:0]             grant_id,
  output logic [3:0]             dac_signals_15
);

  localparam int PH_N  = 2 * HALF_PERIOD;
  localparam int MAX_A = (PH_N > LD_CYCLES) ? PH_N : LD_CYCLES;
  localparam int MAX_B = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
  localparam int MAX_C = (MAX_B > CLR_CYCLES) ? MAX_B : CLR_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);

  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t PH_LAST  = cnt_t'(PH_N - 1);
  localparam cnt_t HP_C     = cnt_t'(HALF_PERIOD);
  localparam cnt_t LD_LAST  = cnt_t'(LD_CYCLES - 1);
  localparam cnt_t GAP_LAST = cnt_t'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam cnt_t CLR_LAST = cnt_t'(CLR_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_LOAD, S_GAP, S_CLEAR} state_t;

  state_t      state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [11:0] data_q, data_d;
  logic [2:0]  rr_q, rr_d;
  logic        pend_q, pend_d;
  logic [2:0]  gid_q, gid_d;
  logic        busy_q, busy_d;
  logic        ack_q, ack_d;
  logic [3:0]  dac_q, dac_d;

  logic [2:0]  gnt_idx;
  logic        gnt_found;
  logic [11:0] sel_data;
  logic        grant_now;

  // Two passes: indices above the pointer first, then wrap to the low ones.
  always_comb begin
    gnt_idx   = '0;
    gnt_found = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && req_valid[i] && (3'(i) > rr_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = 3'(i);
        sel_data  = req_data[12*i +: 12];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && req_valid[i] && (3'(i) <= rr_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = 3'(i);
        sel_data  = req_data[12*i +: 12];
      end
    end
  end

  assign grant_now = (state_q == S_IDLE) && !pend_q && !clr_req && gnt_found;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant_now && (gnt_idx == 3'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    rr_d    = rr_q;
    gid_d   = gid_q;
    pend_d  = pend_q | clr_req;
    case (state_q)
      S_IDLE: begin
        if (pend_q || clr_req) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end else if (gnt_found) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          bit_d   = 4'd11;
          data_d  = sel_data;
          rr_d    = gnt_idx;
          gid_d   = gnt_idx;
        end
      end
      S_SHIFT: begin
        if (cnt_q == PH_LAST) begin
          cnt_d = '0;
          if (bit_q == 4'd0) state_d = S_LOAD;
          else               bit_d   = bit_q - 4'd1;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      S_LOAD: begin
        if (cnt_q == LD_LAST) begin
          cnt_d   = '0;
          state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      S_CLEAR: begin
        if (cnt_q == CLR_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (state_d == S_CLEAR && state_q != S_CLEAR) pend_d = 1'b0;

    // Pins are decoded from next-state values so they land registered and in phase.
    busy_d = (state_d != S_IDLE);
    ack_d  = (state_d == S_CLEAR) && (cnt_d == CLR_LAST);
    case (state_d)
      S_SHIFT: dac_d = {(cnt_d >= HP_C), data_d[bit_d], 2'b11};
      S_LOAD:  dac_d = 4'b1101;
      S_CLEAR: dac_d = 4'b1110;
      default: dac_d = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      rr_q    <= 3'(NUM_REQ - 1);
`ifdef DAC_CLR_ON_RESET_EN
      pend_q  <= 1'b1;
`else
      pend_q  <= 1'b0;
`endif
      gid_q   <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      dac_q   <= 4'b1111;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      rr_q    <= rr_d;
      pend_q  <= pend_d;
      gid_q   <= gid_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      dac_q   <= dac_d;
    end
  end

  assign clr_ack        = ack_q;
  assign busy           = busy_q;
  assign grant_id       = gid_q;
  assign dac_signals_15 = dac_q;

endmodule

// File: tb/tb_dac7611_arbiter.sv
// Bench for dac7611_arbiter: two configurations driven by shared random stimulus,
// each checked against a frame-timeline reference model and a pin-level word decoder.
module tb_dac7611_arbiter;
  localparam int NR  = 2;
  localparam int LD  = 2;
  localparam int CLR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [NR-1:0] req_valid;
  logic [23:0]   req_data;
  logic          clr_req;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  for (genvar c = 0; c < 2; c++) begin : g_cfg
    localparam int HP   = (c == 0) ? 2 : 1;
    localparam int GAP  = (c == 0) ? 4 : 0;
    localparam int SLEN = 24 * HP;
    localparam int FLEN = SLEN + LD + GAP;

    logic [NR-1:0] rdy;
    logic          ack, bsy;
    logic [2:0]    gid;
    logic [3:0]    pins;

    dac7611_arbiter #(
      .NUM_REQ(NR), .HALF_PERIOD(HP), .LD_CYCLES(LD),
      .GAP_CYCLES(GAP), .CLR_CYCLES(CLR)
    ) u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(rdy), .clr_req(clr_req), .clr_ack(ack), .busy(bsy),
      .grant_id(gid), .dac_signals_15(pins)
    );

    // Model: act 0 idle, 1 data frame, 2 clear; k is the 1-based cycle within it.
    int          act = 0, k = 0, mgid = 0, mrr = NR - 1;
    bit          pend = 1'b0, live = 1'b0, exp_live = 1'b0;
    logic [11:0] mdata = '0, exp_word = '0, word = '0;
    logic [3:0]  prev_pins = 4'hF;
    int          nbits = 0;

    always @(negedge clk) begin
      logic [3:0]    ep;
      logic [NR-1:0] er;
      int            g;
      bit            found;
      ep = 4'hF; er = '0; g = 0; found = 1'b0;
      for (int j = 1; j <= NR; j++) begin
        if (!found && req_valid[(mrr + j) % NR]) begin
          found = 1'b1;
          g = (mrr + j) % NR;
        end
      end
      if (live) begin
        if (act == 1) begin
          if (k <= SLEN)
            ep = {(((k - 1) % (2 * HP)) >= HP), mdata[11 - (k - 1) / (2 * HP)], 2'b11};
          else if (k <= SLEN + LD)
            ep = 4'b1101;
        end else if (act == 2) begin
          ep = 4'b1110;
        end
        if (act == 0 && !pend && !clr_req && found) er = NR'(1) << g;
        chk($sformatf("c%0d_pins", c), 32'(pins), 32'(ep));
        chk($sformatf("c%0d_busy", c), 32'(bsy), 32'(act != 0));
        chk($sformatf("c%0d_ack", c), 32'(ack), 32'(act == 2 && k == CLR));
        chk($sformatf("c%0d_gid", c), 32'(gid), 32'(mgid));
        chk($sformatf("c%0d_ready", c), 32'(rdy), 32'(er));
        // Independent view: decode SDI at CLK rises, compare at LD falling edge.
        if (!prev_pins[3] && pins[3]) begin
          word = {word[10:0], pins[2]};
          nbits++;
        end
        if (prev_pins[1] && !pins[1]) begin
          chk($sformatf("c%0d_ld_live", c), 32'(exp_live), 32'd1);
          chk($sformatf("c%0d_ld_bits", c), 32'(nbits), 32'd12);
          chk($sformatf("c%0d_ld_word", c), 32'(word), 32'(exp_word));
          exp_live = 1'b0;
        end
      end
      prev_pins = pins;

      if (reset) begin
        act = 0; k = 0; mgid = 0; mrr = NR - 1; live = 1'b1; exp_live = 1'b0;
`ifdef DAC_CLR_ON_RESET_EN
        pend = 1'b1;
`else
        pend = 1'b0;
`endif
      end else if (live) begin
        if (act == 0) begin
          if (pend || clr_req) begin
            act = 2; k = 1; pend = 1'b0;
          end else if (found) begin
            act = 1; k = 1; mgid = g; mrr = g;
            mdata = req_data[12*g +: 12];
            exp_word = mdata; exp_live = 1'b1; word = '0; nbits = 0;
          end
        end else begin
          pend = pend | clr_req;
          k++;
          if ((act == 1 && k > FLEN) || (act == 2 && k > CLR)) begin
            act = 0; k = 0;
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_data = '0; clr_req = 1'b0;
    step(3);
    // Single write of 12'hA5C from requester 0.
    reset = 1'b0; req_valid = 2'b01; req_data = {12'h222, 12'hA5C};
    step(1);
    req_valid = '0;
    step(70);
    // Both requesters continuously valid: grants must alternate.
    req_valid = 2'b11; req_data = {12'h222, 12'h111};
    step(240);
    req_valid = '0;
    step(60);
    // Clear and data request in the same idle cycle.
    clr_req = 1'b1; req_valid = 2'b10;
    step(1);
    clr_req = 1'b0;
    step(10);
    req_valid = '0;
    step(60);
    // Clear pulsed in the middle of a shift.
    req_valid = 2'b01; req_data = {12'h5A3, 12'h3C7};
    step(1);
    req_valid = '0;
    step(10);
    clr_req = 1'b1;
    step(1);
    clr_req = 1'b0;
    step(80);
    // Reset in the middle of a shift, then both valid.
    req_valid = 2'b10; req_data = {12'hFA0, 12'h05F};
    step(1);
    req_valid = '0;
    step(20);
    reset = 1'b1;
    step(1);
    reset = 1'b0; req_valid = 2'b11;
    step(1);
    req_valid = '0;
    step(60);
    // Random traffic.
    for (int n = 0; n < 6000; n++) begin
      if ($urandom_range(0, 3) == 0) req_valid = NR'($urandom_range(0, 3));
      req_data = 24'($urandom);
      clr_req  = ($urandom_range(0, 49) == 0);
      reset    = ($urandom_range(0, 599) == 0);
      step(1);
    end
    reset = 1'b0; req_valid = '0; clr_req = 1'b0;
    step(100);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
